// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: operation codes, branch-compare
// codes and the multiply/divide sequencer states.
package alu_pkg;

  localparam int unsigned ALUCONF_W = 5;
  localparam int unsigned BRANCH_W  = 3;

  localparam logic [ALUCONF_W-1:0] ALU_ADD  = 5'b00000;
  localparam logic [ALUCONF_W-1:0] ALU_OR   = 5'b00001;
  localparam logic [ALUCONF_W-1:0] ALU_AND  = 5'b00010;
  localparam logic [ALUCONF_W-1:0] ALU_SUB  = 5'b00110;
  localparam logic [ALUCONF_W-1:0] ALU_SLT  = 5'b00111;
  localparam logic [ALUCONF_W-1:0] ALU_NOR  = 5'b01100;
  localparam logic [ALUCONF_W-1:0] ALU_XOR  = 5'b01101;
  localparam logic [ALUCONF_W-1:0] ALU_SRL  = 5'b10000;
  localparam logic [ALUCONF_W-1:0] ALU_SRA  = 5'b11000;
  localparam logic [ALUCONF_W-1:0] ALU_SLL  = 5'b11001;
  localparam logic [ALUCONF_W-1:0] ALU_MFHI = 5'b11010;
  localparam logic [ALUCONF_W-1:0] ALU_MFLO = 5'b11011;
  localparam logic [ALUCONF_W-1:0] ALU_MUL  = 5'b10100;
  localparam logic [ALUCONF_W-1:0] ALU_DIV  = 5'b10101;
  localparam logic [ALUCONF_W-1:0] ALU_MTHI = 5'b11100;
  localparam logic [ALUCONF_W-1:0] ALU_MTLO = 5'b11101;

  localparam logic [BRANCH_W-1:0] BR_LTZ = 3'b001;
  localparam logic [BRANCH_W-1:0] BR_EQ  = 3'b100;
  localparam logic [BRANCH_W-1:0] BR_NE  = 3'b101;
  localparam logic [BRANCH_W-1:0] BR_LEZ = 3'b110;
  localparam logic [BRANCH_W-1:0] BR_GTZ = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_seq.sv
// Iterative multiply/divide sequencer: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, sign fix-up, and the HI/LO registers.
module mdu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             div_i,
  input  logic             sign_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  mdu_state_e       state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] whi_q, whi_d, wlo_q, wlo_d, mb_q, mb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d, neg_q, neg_d, rneg_q, rneg_d;
  logic             divz_q, divz_d, done_q, done_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod;

  assign a_neg = sign_i & a_i[WIDTH-1];
  assign b_neg = sign_i & b_i[WIDTH-1];
  assign a_mag = a_neg ? WIDTH'(-a_i) : a_i;
  assign b_mag = b_neg ? WIDTH'(-b_i) : b_i;

  // One radix-2 step; whi holds partial product / remainder, wlo multiplier / quotient.
  assign mul_sum  = {1'b0, whi_q} + (wlo_q[0] ? {1'b0, mb_q} : (WIDTH+1)'(0));
  assign div_sh   = {whi_q, wlo_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, mb_q};
  assign prod     = neg_q ? (2*WIDTH)'(-{whi_q, wlo_q}) : {whi_q, wlo_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      whi_q   <= '0;
      wlo_q   <= '0;
      mb_q    <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      divz_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      whi_q   <= whi_d;
      wlo_q   <= wlo_d;
      mb_q    <= mb_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      divz_q  <= divz_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    whi_d   = whi_q;
    wlo_d   = wlo_q;
    mb_d    = mb_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    divz_d  = divz_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          whi_d   = '0;
          wlo_d   = a_mag;
          mb_d    = b_mag;
          cnt_d   = CNT_W'(WIDTH-1);
          div_d   = div_i;
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          divz_d  = (b_i == '0);
        end else begin
          if (mthi_i) hi_d = a_i;
          if (mtlo_i) lo_d = a_i;
        end
      end
      S_RUN: begin
        if (div_q) begin
          if (!div_diff[WIDTH]) begin
            whi_d = div_diff[WIDTH-1:0];
            wlo_d = {wlo_q[WIDTH-2:0], 1'b1};
          end else begin
            whi_d = div_sh[WIDTH-1:0];
            wlo_d = {wlo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          whi_d = mul_sum[WIDTH:1];
          wlo_d = {mul_sum[0], wlo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (div_q) begin
          // A zero divisor leaves the dividend magnitude in whi, so only LO needs forcing.
          lo_d = divz_q ? '1 : (neg_q ? WIDTH'(-wlo_q) : wlo_q);
          hi_d = rneg_q ? WIDTH'(-whi_q) : whi_q;
        end else begin
          {hi_d, lo_d} = prod;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU: combinational arithmetic/logic/shift/compare paths plus the
// sequential multiply/divide unit with its pipeline stall handshake.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ALUCONF_W-1:0] ALUConf,
  input  logic                 Sign,
  input  logic [BRANCH_W-1:0]  Branch,
  input  logic [WIDTH-1:0]     In1,
  input  logic [WIDTH-1:0]     In2,
  input  logic                 Start,
  output logic [WIDTH-1:0]     Result,
  output logic                 Comp,
  output logic                 Busy,
  output logic                 Stall,
  output logic                 Done,
  output logic [WIDTH-1:0]     Hi,
  output logic [WIDTH-1:0]     Lo
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  logic [SHAMT_W-1:0] shamt;
  logic               lt, is_muldiv, is_mf;
  logic               accept, mthi_we, mtlo_we;
  logic               busy;
  logic [WIDTH-1:0]   hi, lo;

  assign shamt     = In1[SHAMT_W-1:0];
  assign lt        = Sign ? ($signed(In1) < $signed(In2)) : (In1 < In2);
  assign is_muldiv = (ALUConf == ALU_MUL) || (ALUConf == ALU_DIV);
  assign is_mf     = (ALUConf == ALU_MFHI) || (ALUConf == ALU_MFLO);
  assign accept    = Start && is_muldiv && !busy;
  assign mthi_we   = Start && (ALUConf == ALU_MTHI) && !busy;
  assign mtlo_we   = Start && (ALUConf == ALU_MTLO) && !busy;

  always_comb begin
    Result = '0;
    case (ALUConf)
      ALU_ADD:  Result = In1 + In2;
      ALU_OR:   Result = In1 | In2;
      ALU_AND:  Result = In1 & In2;
      ALU_SUB:  Result = In1 - In2;
      ALU_SLT:  Result = {{(WIDTH-1){1'b0}}, lt};
      ALU_NOR:  Result = ~(In1 | In2);
      ALU_XOR:  Result = In1 ^ In2;
      ALU_SRL:  Result = In2 >> shamt;
      ALU_SRA:  Result = WIDTH'($signed(In2) >>> shamt);
      ALU_SLL:  Result = In2 << shamt;
      ALU_MFHI: Result = hi;
      ALU_MFLO: Result = lo;
      default:  Result = '0;
    endcase
  end

  always_comb begin
    Comp = 1'b0;
    case (Branch)
      BR_EQ:   Comp = (In1 == In2);
      BR_NE:   Comp = (In1 != In2);
      BR_LEZ:  Comp = In1[WIDTH-1] || (In1 == '0);
      BR_GTZ:  Comp = !In1[WIDTH-1] && (In1 != '0);
      BR_LTZ:  Comp = In1[WIDTH-1];
      default: Comp = 1'b0;
    endcase
  end

  mdu_seq #(.WIDTH(WIDTH)) u_mdu (
    .clk     (clk),
    .reset   (reset),
    .start_i (accept),
    .div_i   (ALUConf == ALU_DIV),
    .sign_i  (Sign),
    .a_i     (In1),
    .b_i     (In2),
    .mthi_i  (mthi_we),
    .mtlo_i  (mtlo_we),
    .busy_o  (busy),
    .done_o  (Done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  assign Busy  = busy;
  assign Stall = busy && (Start || is_mf);
  assign Hi    = hi;
  assign Lo    = lo;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed and random combinational ops against
// an arithmetic model, plus multiply/divide latency, handshake and reset cases.
`timescale 1ns/1ps
module tb_alu_mdu;
  import alu_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned LAT = W + 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [ALUCONF_W-1:0] ALUConf;
  logic                 Sign;
  logic [BRANCH_W-1:0]  Branch;
  logic [W-1:0]         In1, In2;
  logic                 Start;
  logic [W-1:0]         Result;
  logic                 Comp, Busy, Stall, Done;
  logic [W-1:0]         Hi, Lo;

  int errs = 0;
  int checks = 0;
  logic [W-1:0] mdl_hi, mdl_lo, exp_hi, exp_lo;
  logic [W-1:0] ra, rb;
  logic [ALUCONF_W-1:0] rc;
  logic rs;
  int n_done;

  alu_mdu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .ALUConf(ALUConf), .Sign(Sign), .Branch(Branch),
    .In1(In1), .In2(In2), .Start(Start), .Result(Result), .Comp(Comp),
    .Busy(Busy), .Stall(Stall), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [4:0] c, input logic s,
      input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] h, input logic [W-1:0] l);
    logic [4:0] sh;
    sh = a[4:0];
    case (c)
      5'b00000: return a + b;
      5'b00001: return a | b;
      5'b00010: return a & b;
      5'b00110: return a - b;
      5'b00111: return s ? W'($signed(a) < $signed(b)) : W'(a < b);
      5'b01100: return ~(a | b);
      5'b01101: return a ^ b;
      5'b10000: return b >> sh;
      5'b11000: return W'($signed(b) >>> sh);
      5'b11001: return b << sh;
      5'b11010: return h;
      5'b11011: return l;
      default:  return '0;
    endcase
  endfunction

  function automatic logic ref_comp(input logic [2:0] br, input logic [W-1:0] a, input logic [W-1:0] b);
    case (br)
      3'b100:  return a == b;
      3'b101:  return a != b;
      3'b110:  return $signed(a) <= 0;
      3'b111:  return $signed(a) > 0;
      3'b001:  return $signed(a) < 0;
      default: return 1'b0;
    endcase
  endfunction

  // Mathematical product / truncating quotient computed in 64-bit integers.
  function automatic void mdu_ref(input logic is_div, input logic sgn, input logic [W-1:0] a,
      input logic [W-1:0] b, output logic [W-1:0] h, output logic [W-1:0] l);
    longint sa, sb;
    logic [63:0] p, q, r;
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (!is_div) begin
      p = 64'(sa * sb);
      h = p[63:32];
      l = p[31:0];
    end else if (b == '0) begin
      h = a;
      l = '1;
    end else begin
      q = 64'(sa / sb);
      r = 64'(sa % sb);
      h = r[31:0];
      l = q[31:0];
    end
  endfunction

  task automatic accept(input logic [4:0] c, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    ALUConf = c; Sign = s; In1 = a; In2 = b; Start = 1'b1;
    mdu_ref(c == ALU_DIV, s, a, b, exp_hi, exp_lo);
    tick();
    Start = 1'b0; ALUConf = ALU_ADD;
    In1 = $urandom; In2 = $urandom; Sign = $urandom_range(0, 1);
  endtask

  task automatic wait_done(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (Busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    chk({tag, "_lat"}, 64'(n), 64'(exp_cycles));
    chk({tag, "_done"}, 64'(Done), 64'(1));
    chk({tag, "_hi"}, 64'(Hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(Lo), 64'(exp_lo));
    mdl_hi = exp_hi;
    mdl_lo = exp_lo;
  endtask

  initial begin
    reset = 1'b1; ALUConf = ALU_ADD; Sign = 1'b0; Branch = 3'b000;
    In1 = '0; In2 = '0; Start = 1'b0;
    mdl_hi = '0; mdl_lo = '0;
    tick(); tick();
    chk("rst_busy", 64'(Busy), 64'(0));
    chk("rst_done", 64'(Done), 64'(0));
    chk("rst_hi", 64'(Hi), 64'(0));
    chk("rst_lo", 64'(Lo), 64'(0));
    reset = 1'b0;
    tick();

    // Directed combinational cases.
    ALUConf = ALU_SRA; In1 = 32'd4; In2 = 32'h8000_0000; #1;
    chk("sra", 64'(Result), 64'(32'hF800_0000));
    ALUConf = ALU_SLT; Sign = 1'b1; In1 = 32'hFFFF_FFFF; In2 = 32'd1; #1;
    chk("slt_s", 64'(Result), 64'(1));
    Sign = 1'b0; #1;
    chk("slt_u", 64'(Result), 64'(0));
    Branch = BR_LEZ; In1 = '0; #1;
    chk("br_lez0", 64'(Comp), 64'(1));
    Branch = BR_GTZ; #1;
    chk("br_gtz0", 64'(Comp), 64'(0));

    // Random combinational ops, including unused codes.
    for (int i = 0; i < 60; i++) begin
      ALUConf = 5'($urandom); Sign = $urandom_range(0, 1); Branch = 3'($urandom);
      In1 = $urandom; In2 = (i % 7 == 0) ? In1 : $urandom;
      #1;
      chk("rnd_result", 64'(Result), 64'(ref_alu(ALUConf, Sign, In1, In2, mdl_hi, mdl_lo)));
      chk("rnd_comp", 64'(Comp), 64'(ref_comp(Branch, In1, In2)));
    end

    // Move-to while idle.
    tick();
    ALUConf = ALU_MTHI; In1 = 32'h1234; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("mthi_hi", 64'(Hi), 64'(32'h1234));
    chk("mthi_busy", 64'(Busy), 64'(0));
    ALUConf = ALU_MTLO; In1 = 32'h5678; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("mtlo_lo", 64'(Lo), 64'(32'h5678));
    ALUConf = ALU_MFHI; #1;
    chk("mfhi", 64'(Result), 64'(32'h1234));
    mdl_hi = 32'h1234; mdl_lo = 32'h5678;

    // Directed multiply/divide cases.
    accept(ALU_MUL, 1'b1, -32'sd3, 32'd5);
    chk("mult_busy", 64'(Busy), 64'(1));
    wait_done("mult", LAT);
    chk("mult_hi_c", 64'(Hi), 64'(32'hFFFF_FFFF));
    chk("mult_lo_c", 64'(Lo), 64'(32'hFFFF_FFF1));
    tick();
    chk("done_pulse", 64'(Done), 64'(0));
    accept(ALU_MUL, 1'b0, 32'hFFFF_FFFF, 32'd2);  wait_done("multu", LAT);
    accept(ALU_DIV, 1'b0, 32'd100, 32'd7);        wait_done("divu", LAT);
    chk("divu_lo_c", 64'(Lo), 64'(14));
    accept(ALU_DIV, 1'b1, -32'sd7, 32'd2);        wait_done("div_neg", LAT);
    chk("div_neg_hi_c", 64'(Hi), 64'(32'hFFFF_FFFF));
    accept(ALU_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF); wait_done("div_ovf", LAT);
    chk("div_ovf_lo_c", 64'(Lo), 64'(32'h8000_0000));
    accept(ALU_DIV, 1'b0, 32'd9, 32'd0);          wait_done("divu_z", LAT);
    accept(ALU_DIV, 1'b1, -32'sd5, 32'd0);        wait_done("div_z", LAT);

    // Handshake: mflo, second Start and mtlo during Busy all stall without effect.
    accept(ALU_MUL, 1'b1, 32'h0001_2345, -32'sd77);
    tick(); tick();
    ALUConf = ALU_MFLO; Start = 1'b0; #1;
    chk("stall_mflo", 64'(Stall), 64'(1));
    ALUConf = ALU_ADD; #1;
    chk("no_stall_add", 64'(Stall), 64'(0));
    ALUConf = ALU_DIV; Start = 1'b1; In1 = 32'd50; In2 = 32'd3; #1;
    chk("stall_start", 64'(Stall), 64'(1));
    tick();
    ALUConf = ALU_MTLO; In1 = 32'hDEAD_BEEF; #1;
    chk("stall_mtlo", 64'(Stall), 64'(1));
    tick();
    Start = 1'b0; ALUConf = ALU_ADD;
    chk("busy_hi_kept", 64'(Hi), 64'(mdl_hi));
    chk("busy_lo_kept", 64'(Lo), 64'(mdl_lo));
    wait_done("inflight", LAT - 4);
    // Back-to-back Start in the Done cycle.
    chk("b2b_idle", 64'(Busy), 64'(0));
    accept(ALU_DIV, 1'b0, 32'hFFFF_FFF0, 32'd13);
    chk("b2b_busy", 64'(Busy), 64'(1));
    wait_done("b2b", LAT);

    // Random multiply/divide.
    for (int i = 0; i < 16; i++) begin
      ra = $urandom; rb = (i % 5 == 0) ? W'($urandom_range(0, 3)) : $urandom;
      rc = (i % 2 == 0) ? ALU_MUL : ALU_DIV;
      rs = $urandom_range(0, 1);
      accept(rc, rs, ra, rb);
      wait_done("rnd_mdu", LAT);
    end

    // Reset mid-operation aborts without Done.
    accept(ALU_MUL, 1'b0, 32'd1000, 32'd1000);
    for (int i = 0; i < 10; i++) tick();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", 64'(Busy), 64'(0));
    chk("abort_hi", 64'(Hi), 64'(0));
    chk("abort_lo", 64'(Lo), 64'(0));
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (Done === 1'b1) n_done++;
    end
    chk("abort_no_done", 64'(n_done), 64'(0));
    accept(ALU_MUL, 1'b1, 32'd6, 32'd7);
    wait_done("post_rst", LAT);
    chk("post_rst_lo42", 64'(Lo), 64'(42));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
Next-generation execute-stage ALU, parametrised in data width. Keeps the single-cycle arithmetic, logic, shift, set-less-than and branch-compare operations as combinational paths. Adds a sequential multiply/divide unit (MULT, MULTU, DIV, DIVU) with HI/LO registers, move-to and move-from operations, and a Busy/Stall/Done handshake to the pipeline control.

Parameters:
WIDTH, 32, datapath width in bits; must be a power of two and at least 8.
SHAMT_W, $clog2(WIDTH), derived, not overridable; number of low In1 bits used as the shift amount.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
ALUConf  in  5  operation select.
Sign  in  1  1 = signed compare and signed multiply/divide.
Branch  in  3  branch-compare select.
In1  in  WIDTH  operand A (rs); also the shift amount.
In2  in  WIDTH  operand B (rt); also the shift data.
Start  in  1  qualifies a multiply/divide or move-to operation this cycle.
Result  out  WIDTH  combinational result.
Comp  out  1  combinational branch condition.
Busy  out  1  multiply/divide unit not idle.
Stall  out  1  pipeline must hold the current instruction.
Done  out  1  one-cycle pulse when HI/LO have been updated by multiply/divide.
Hi  out  WIDTH  HI register.
Lo  out  WIDTH  LO register.

Behaviour:
- Reset: one clock, asynchronous and active-high. While reset is high: state=IDLE; HI, LO, counter and working registers = 0; Busy=0; Done=0.
- Combinational ALUConf codes (Result):
  - 00000 add; 00001 or; 00010 and; 00110 sub.
  - 00111 slt: Sign=1 signed, Sign=0 unsigned; result zero-extended.
  - 01100 nor; 01101 xor.
  - 10000 srl, 11000 sra, 11001 sll: shift In2 by In1[SHAMT_W-1:0].
  - 11010 mfhi: Result=HI. 11011 mflo: Result=LO.
  - Any other code: Result=0.
- Comp from Branch:
  - 100: In1==In2. 101: In1!=In2.
  - 110: In1<=0 signed. 111: In1>0 signed. 001: In1<0.
  - Any other code: 0.
- Multi-cycle ALUConf codes, acted on only when Start=1:
  - 10100 mul: Sign selects MULT or MULTU.
  - 10101 div: Sign selects DIV or DIVU.
  - 11100 mthi: HI<=In1 at the clock edge, only when not Busy.
  - 11101 mtlo: LO<=In1 at the clock edge, only when not Busy.
  - Start with any other code: no effect.
- FSM states: IDLE, RUN, FIX.
  - IDLE -> RUN on an edge with Start and a mul/div code. That edge latches magnitudes of the operands, the op, the sign flags, and counter=WIDTH-1.
  - RUN: one radix-2 step per cycle (shift-add multiply, restoring divide); counter decrements. RUN -> FIX at counter=0, giving exactly WIDTH RUN cycles.
  - FIX: sign correction. The edge leaving FIX writes HI/LO and returns to IDLE.
  - Mul: {HI,LO} = 2*WIDTH-bit product.
  - Div: LO=quotient, HI=remainder. Quotient truncates toward zero; remainder takes the sign of the dividend.
- Timing: Busy = (state!=IDLE), high for WIDTH+1 cycles after the accept edge. Done is registered and high for the single cycle after the HI/LO write. Busy=0 in that same cycle, so a back-to-back Start is accepted there.
- Stall = Busy AND (Start OR ALUConf in {mfhi, mflo}). While Stall=1, the op is not accepted and mfhi/mflo Result is don't-care.
- Divide by zero: LO = all ones, HI = dividend. Full latency, no exception.
- Signed overflow (MIN / -1): LO=MIN, HI=0.
- Start while Busy is ignored; the in-flight operation is unaffected.
- Reset asserted mid-operation aborts it; no Done is produced.
- Operands may change after the accept edge without affecting the result.

Decomposition:
- Shared package alu_pkg: ALUConf code localparams, Branch code localparams, FSM state enum.
- One natural sub-module, mdu_seq: the FSM, counter, iterative datapath, HI/LO and handshake. The top level holds the combinational ALU, the Comp logic and the Stall logic.

Test Plan (WIDTH=32):
- Combinational ops: In1=4, In2=0x80000000, sra -> 0xF8000000. slt with Sign=1, In1=0xFFFFFFFF, In2=1 -> 1; Sign=0 -> 0. Branch 110, In1=0 -> Comp=1.
- MULT: Sign=1, In1=-3, In2=5, Start one cycle -> Busy for 33 cycles, then Done pulse; HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULTU 0xFFFFFFFF*2 -> HI=1, LO=0xFFFFFFFE.
- Divide: DIVU 100/7 -> LO=14, HI=2. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/-1 -> LO=0x80000000, HI=0. DIVU 9/0 -> LO=0xFFFFFFFF, HI=9.
- Handshake: mflo or a second Start during Busy -> Stall=1 and HI/LO unchanged. Start in the Done cycle -> accepted, Busy stays high.
- MTHI 0x1234 while idle -> HI=0x1234 next cycle, Busy stays 0. MTLO during Busy -> Stall=1, LO unchanged.
- Reset pulse at RUN cycle 10 -> Busy=0, HI=LO=0, no Done. A subsequent MULT 6*7 -> LO=42.
